// File: rtl/goertzel_power_sequencer.sv
// Captures a frame of NF signed Goertzel results, squares them on one shared multiplier and tracks the peak bin.
// Latency: done_o rises NF+2 cycles after valid_i goes all-high; no backpressure, a trigger while busy only sets overrun_o.
module goertzel_power_sequencer #(
  parameter int NF = 11,
  parameter int DW = 32,
  localparam int AW = $clog2(2*NF+2)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NF-1:0]    valid_i,
  input  logic [NF*DW-1:0] data_i,
  input  logic             clear_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [31:0]      rd_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overrun_o,
  output logic [7:0]       peak_idx_o
);

  localparam int PW = 2*DW;
  localparam int KW = (NF > 1) ? $clog2(NF) : 1;
  localparam int XW = (PW > 64) ? PW : 64;
  localparam logic [KW-1:0] K_LAST = KW'(NF-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  all_q, all_d;
  logic signed [DW-1:0]  cap_q [NF];
  logic signed [DW-1:0]  cap_d [NF];
  logic [PW-1:0]         pwr_q [NF];
  logic [PW-1:0]         pwr_d [NF];
  logic [PW-1:0]         prod_q, prod_d;
  logic                  wb_vld_q, wb_vld_d;
  logic [KW-1:0]         wb_idx_q, wb_idx_d;
  logic [KW-1:0]         k_q, k_d;
  logic [PW-1:0]         peak_pwr_q, peak_pwr_d;
  logic [7:0]            peak_run_q, peak_run_d;
  logic [7:0]            peak_idx_q, peak_idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic [31:0]           rd_data_q, rd_data_d;

  logic                  trig;
  logic [PW-1:0]         cap_x;
  logic [PW-1:0]         sq;

  assign all_d = &valid_i;
  assign trig  = all_d & ~all_q;

  // Sign-extend before squaring so the low PW bits hold the exact square.
  assign cap_x = {{DW{cap_q[k_q][DW-1]}}, cap_q[k_q]};
  assign sq    = cap_x * cap_x;

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    pwr_d       = pwr_q;
    prod_d      = prod_q;
    wb_vld_d    = 1'b0;
    wb_idx_d    = wb_idx_q;
    k_d         = k_q;
    peak_pwr_d  = peak_pwr_q;
    peak_run_d  = peak_run_q;
    peak_idx_d  = peak_idx_q;
    busy_d      = busy_q;
    done_d      = done_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;

    // Write-back stage trails the multiplier by one cycle; strict compare keeps the lower index on ties.
    if (wb_vld_q) begin
      pwr_d[wb_idx_q] = prod_q;
      if (prod_q > peak_pwr_q) begin
        peak_pwr_d = prod_q;
        peak_run_d = 8'(wb_idx_q);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          for (int k = 0; k < NF; k++) begin
            cap_d[k] = data_i[k*DW +: DW];
          end
          k_d        = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          peak_pwr_d = '0;
          peak_run_d = 8'd0;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        prod_d   = sq;
        wb_vld_d = 1'b1;
        wb_idx_d = k_q;
        k_d      = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        frame_cnt_d = frame_cnt_q + 8'd1;
        peak_idx_d  = peak_run_d;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (trig && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    // Clear wins over everything except a trigger accepted from IDLE.
    if (clear_i) begin
      done_d    = 1'b0;
      overrun_d = 1'b0;
      if (state_q != S_IDLE) begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        wb_vld_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        peak_idx_d  = peak_idx_q;
      end
    end
  end

  always_comb begin
    logic [XW-1:0] pwr_x;
    pwr_x     = '0;
    rd_data_d = 32'd0;
    if (rd_addr_i == AW'(0)) begin
      rd_data_d = {16'd0, frame_cnt_q, 5'd0, overrun_q, done_q, busy_q};
    end else if (rd_addr_i == AW'(1)) begin
      rd_data_d = {24'd0, peak_idx_q};
    end
    for (int k = 0; k < NF; k++) begin
      pwr_x = XW'(pwr_q[k]);
      if (rd_addr_i == AW'(2*k+2)) rd_data_d = pwr_x[31:0];
      if (rd_addr_i == AW'(2*k+3)) rd_data_d = pwr_x[63:32];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      all_q       <= 1'b0;
      cap_q       <= '{default: '0};
      pwr_q       <= '{default: '0};
      prod_q      <= '0;
      wb_vld_q    <= 1'b0;
      wb_idx_q    <= '0;
      k_q         <= '0;
      peak_pwr_q  <= '0;
      peak_run_q  <= 8'd0;
      peak_idx_q  <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      rd_data_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      all_q       <= all_d;
      cap_q       <= cap_d;
      pwr_q       <= pwr_d;
      prod_q      <= prod_d;
      wb_vld_q    <= wb_vld_d;
      wb_idx_q    <= wb_idx_d;
      k_q         <= k_d;
      peak_pwr_q  <= peak_pwr_d;
      peak_run_q  <= peak_run_d;
      peak_idx_q  <= peak_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overrun_o  = overrun_q;
  assign peak_idx_o = peak_idx_q;

endmodule
